// File: rtl/flash_rom_pkg.sv
// Shared types and boot image for the flash ROM boot loader.
// rom_word() is the single source of the image; unpopulated entries read as zero.
package flash_rom_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int ROM_POPULATED  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } boot_state_e;

  // Returned 32 bits wide; callers narrow it to their own word width.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] w;
    w = 32'd0;
    if (addr < 32'(ROM_POPULATED)) begin
      w = 32'h0000_A000 + addr;
    end
    return w;
  endfunction

endpackage

// File: rtl/flash_rom_table.sv
// Combinational boot ROM: zero-latency lookup of the packaged boot image.
module flash_rom_table
  import flash_rom_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  assign data_o = DATA_WIDTH'(rom_word(32'(addr_i)));

endmodule

// File: rtl/flash_rom_boot_loader.sv
// Copies LOAD_COUNT ROM words into instruction memory over a valid/ready port,
// two cycles per word minimum, with a running checksum and an idle-time debug read.
module flash_rom_boot_loader
  import flash_rom_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LOAD_COUNT = 16,
  parameter int DEST_BASE  = 0,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic                  BootStart,
  output logic                  BootBusy,
  output logic                  BootDone,
  output logic [DATA_WIDTH-1:0] Checksum,
  output logic                  WriteValid,
  input  logic                  WriteReady,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  ReadReq,
  input  logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic                  ReadAck,
  output logic [DATA_WIDTH-1:0] ReadData
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(LOAD_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DEST_BASE);
  localparam boot_state_e           RESET_STATE = AUTO_START ? FETCH : IDLE;

  boot_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] cks_q, cks_d;
  logic                  rack_q, rack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wvalid_q, wvalid_d;

  logic [DATA_WIDTH-1:0] boot_word;
  logic [DATA_WIDTH-1:0] dbg_word;

  flash_rom_table #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_boot_rom (
    .addr_i(idx_q),
    .data_o(boot_word)
  );

  flash_rom_table #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dbg_rom (
    .addr_i(ReadAddress),
    .data_o(dbg_word)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cks_d     = cks_q;
    rack_d    = 1'b0;
    rdata_d   = rdata_q;

    case (state_q)
      IDLE, DONE: begin
        // Boot has priority; a held ReadReq is served once the load completes.
        if (BootStart) begin
          state_d = FETCH;
          idx_d   = '0;
          cks_d   = '0;
        end else if (ReadReq && !rack_q) begin
          rack_d  = 1'b1;
          rdata_d = dbg_word;
        end
      end
      FETCH: begin
        wr_addr_d = BASE_ADDR + idx_q;
        wr_data_d = boot_word;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (WriteReady) begin
          cks_d = cks_q + wr_data_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so reset forces them low.
    busy_d   = (state_d == FETCH) || (state_d == ISSUE);
    done_d   = (state_d == DONE);
    wvalid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= RESET_STATE;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cks_q     <= '0;
      rack_q    <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cks_q     <= cks_d;
      rack_q    <= rack_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wvalid_q  <= wvalid_d;
    end
  end

  assign BootBusy     = busy_q;
  assign BootDone     = done_q;
  assign Checksum     = cks_q;
  assign WriteValid   = wvalid_q;
  assign WriteAddress = wr_addr_q;
  assign WriteData    = wr_data_q;
  assign ReadAck      = rack_q;
  assign ReadData     = rdata_q;

endmodule

// File: tb/tb_flash_rom_boot_loader.sv
// Directed bench: three loader configurations share stimulus; one is observed at a time.
module tb_flash_rom_boot_loader;

  logic       clk;
  logic       rst;
  logic       bstart;
  logic       wr_rdy;
  logic       rreq;
  logic [9:0] raddr;

  logic        a_busy, a_done, a_wv, a_rack;
  logic [15:0] a_cks, a_wd, a_rdata;
  logic [9:0]  a_wa;
  logic        b_busy, b_done, b_wv, b_rack;
  logic [15:0] b_cks, b_wd, b_rdata;
  logic [9:0]  b_wa;
  logic        c_busy, c_done, c_wv, c_rack;
  logic [15:0] c_cks, c_wd, c_rdata;
  logic [9:0]  c_wa;

  logic        x_busy, x_done, x_wv, x_rack;
  logic [15:0] x_cks, x_wd, x_rdata;
  logic [9:0]  x_wa;
  int          sel;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  int done_win;
  logic [9:0]  cap_addr[$];
  logic [15:0] cap_data[$];
  int          cap_win[$];

  flash_rom_boot_loader #(.LOAD_COUNT(16), .DEST_BASE(0), .AUTO_START(1'b1)) u_a (
    .clk(clk), .sync_rst(rst), .BootStart(bstart), .BootBusy(a_busy), .BootDone(a_done),
    .Checksum(a_cks), .WriteValid(a_wv), .WriteReady(wr_rdy), .WriteAddress(a_wa),
    .WriteData(a_wd), .ReadReq(rreq), .ReadAddress(raddr), .ReadAck(a_rack), .ReadData(a_rdata)
  );

  flash_rom_boot_loader #(.LOAD_COUNT(16), .DEST_BASE(0), .AUTO_START(1'b0)) u_b (
    .clk(clk), .sync_rst(rst), .BootStart(bstart), .BootBusy(b_busy), .BootDone(b_done),
    .Checksum(b_cks), .WriteValid(b_wv), .WriteReady(wr_rdy), .WriteAddress(b_wa),
    .WriteData(b_wd), .ReadReq(rreq), .ReadAddress(raddr), .ReadAck(b_rack), .ReadData(b_rdata)
  );

  flash_rom_boot_loader #(.LOAD_COUNT(4), .DEST_BASE(10'h3FE), .AUTO_START(1'b1)) u_c (
    .clk(clk), .sync_rst(rst), .BootStart(bstart), .BootBusy(c_busy), .BootDone(c_done),
    .Checksum(c_cks), .WriteValid(c_wv), .WriteReady(wr_rdy), .WriteAddress(c_wa),
    .WriteData(c_wd), .ReadReq(rreq), .ReadAddress(raddr), .ReadAck(c_rack), .ReadData(c_rdata)
  );

  always_comb begin
    {x_busy, x_done, x_wv, x_rack, x_cks, x_wd, x_rdata, x_wa} =
        {a_busy, a_done, a_wv, a_rack, a_cks, a_wd, a_rdata, a_wa};
    if (sel == 1)
      {x_busy, x_done, x_wv, x_rack, x_cks, x_wd, x_rdata, x_wa} =
          {b_busy, b_done, b_wv, b_rack, b_cks, b_wd, b_rdata, b_wa};
    else if (sel == 2)
      {x_busy, x_done, x_wv, x_rack, x_cks, x_wd, x_rdata, x_wa} =
          {c_busy, c_done, c_wv, c_rack, c_cks, c_wd, c_rdata, c_wa};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ecnt = number of edges since reset release, i.e. the current cycle window.
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (!rst && x_wv && wr_rdy) begin
      cap_addr.push_back(x_wa);
      cap_data.push_back(x_wd);
      cap_win.push_back(ecnt);
    end
    if (!rst && x_done && done_win < 0) done_win = ecnt;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
    cap_win.delete();
    done_win = -1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bstart = 1'b0;
    wr_rdy = 1'b1;
    rreq   = 1'b0;
    raddr  = '0;
    tick();
    tick();
    tick();
    clear_cap();
  endtask

  task automatic check_writes(input string tag, input int n, input logic [9:0] base,
                              input int first_win, input int stall_idx, input int stall_len);
    logic [9:0]  ea;
    logic [15:0] ed;
    int          ew;
    chk({tag, "_count"}, cap_addr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < cap_addr.size()) begin
        ea = base + 10'(i);
        ed = 16'hA000 + 16'(i);
        ew = first_win + 2 * i + ((stall_idx >= 0 && i >= stall_idx) ? stall_len : 0);
        chk($sformatf("%s_addr%0d", tag, i), 32'(cap_addr[i]), 32'(ea));
        chk($sformatf("%s_data%0d", tag, i), 32'(cap_data[i]), 32'(ed));
        chk($sformatf("%s_win%0d", tag, i), cap_win[i], ew);
      end
    end
  endtask

  initial begin
    int ack_win;
    logic [15:0] ack_data;
    sel = 0;
    done_win = -1;

    // Reset state of the auto-start loader
    do_reset();
    chk("rst_busy", x_busy, 0);
    chk("rst_done", x_done, 0);
    chk("rst_cks", x_cks, 0);
    chk("rst_wv", x_wv, 0);
    chk("rst_wa", x_wa, 0);
    chk("rst_wd", x_wd, 0);
    chk("rst_rack", x_rack, 0);
    chk("rst_rdata", x_rdata, 0);

    // Auto-start full load, ready always high
    rst = 1'b0;
    for (int w = 1; w <= 40; w++) begin
      tick();
      if (w == 1) chk("s1_busy_w1", x_busy, 1);
      if (w == 2) chk("s1_wv_drop_w2", x_wv, 0);
      if (w == 32) chk("s1_busy_w32", x_busy, 0);
    end
    check_writes("s1", 16, 10'h000, 1, -1, 0);
    chk("s1_done_win", done_win, 32);
    chk("s1_cks", x_cks, 16'h0078);
    rreq  = 1'b1;
    raddr = 10'd3;
    tick();
    chk("s1_rack", x_rack, 1);
    chk("s1_rdata", x_rdata, 16'hA003);
    rreq = 1'b0;
    tick();
    chk("s1_rack_pulse", x_rack, 0);
    chk("s1_done_sticky", x_done, 1);

    // Backpressure on word 5 plus a debug read held through the load
    do_reset();
    rst     = 1'b0;
    rreq    = 1'b1;
    raddr   = 10'd7;
    ack_win = -1;
    ack_data = '0;
    for (int w = 1; w <= 45; w++) begin
      tick();
      wr_rdy = !(w >= 11 && w <= 13);
      if (w >= 11 && w <= 13) begin
        chk($sformatf("s2_hold_wv%0d", w), x_wv, 1);
        chk($sformatf("s2_hold_wa%0d", w), x_wa, 10'd5);
        chk($sformatf("s2_hold_wd%0d", w), x_wd, 16'hA005);
      end
      if (rreq && x_rack && ack_win < 0) begin
        ack_win  = w;
        ack_data = x_rdata;
        rreq     = 1'b0;
      end
    end
    check_writes("s2", 16, 10'h000, 1, 5, 3);
    chk("s2_done_win", done_win, 35);
    chk("s2_cks", x_cks, 16'h0078);
    chk("s2_ack_win", ack_win, 36);
    chk("s2_ack_data", ack_data, 16'hA007);

    // Reset in the middle of the load, then a clean restart
    do_reset();
    rst = 1'b0;
    for (int w = 1; w <= 15; w++) begin
      tick();
      if (w == 15) begin
        chk("s3_pre_wv", x_wv, 1);
        chk("s3_pre_wa", x_wa, 10'd7);
      end
    end
    rst = 1'b1;
    tick();
    chk("s3_abort_wv", x_wv, 0);
    chk("s3_abort_busy", x_busy, 0);
    chk("s3_abort_wa", x_wa, 0);
    chk("s3_abort_wd", x_wd, 0);
    chk("s3_abort_cks", x_cks, 0);
    clear_cap();
    rst = 1'b0;
    for (int w = 1; w <= 40; w++) tick();
    check_writes("s3", 16, 10'h000, 1, -1, 0);
    chk("s3_done_win", done_win, 32);
    chk("s3_cks", x_cks, 16'h0078);

    // Manual start: idle until BootStart, a second BootStart mid-load is ignored
    sel = 1;
    do_reset();
    rst = 1'b0;
    for (int w = 1; w <= 45; w++) begin
      tick();
      bstart = (w == 5 || w == 15);
      if (w == 5) begin
        chk("s4_idle_writes", cap_addr.size(), 0);
        chk("s4_idle_busy", x_busy, 0);
        chk("s4_idle_done", x_done, 0);
      end
    end
    check_writes("s4", 16, 10'h000, 7, -1, 0);
    chk("s4_done_win", done_win, 38);
    chk("s4_cks", x_cks, 16'h0078);

    // Destination address wrap-around with a 4-word image
    sel = 2;
    do_reset();
    rst = 1'b0;
    for (int w = 1; w <= 20; w++) tick();
    check_writes("s5", 4, 10'h3FE, 1, -1, 0);
    chk("s5_done_win", done_win, 8);
    chk("s5_cks", x_cks, 16'h8006);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
